// File: rtl/dma_write_engine.sv
// DMA write engine: takes a (base address, beat count) command, pulls stream beats and writes each one
// into banked memory after a request/grant handshake. Optional stall counter: DMA_STALL_CNT_EN.
module dma_write_engine #(
    parameter int unsigned                DATA_WIDTH = 32,
    parameter int unsigned                ADDR_WIDTH = 16,
    parameter int unsigned                LEN_WIDTH  = 16,
    parameter int unsigned                BANK_LSB   = 12,
    parameter logic [ADDR_WIDTH-1:0]      CSR_BASE   = 16'hFF00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic [3:0]            mem_bank_req,
    input  logic [3:0]            mem_bank_grant,
    output logic                  done,
    output logic                  error,
`ifdef DMA_STALL_CNT_EN
    output logic [31:0]           stall_cycles,
`endif
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, FETCH, ARB, WRITE, DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  count;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
    logic                  done_q;
    logic                  error_q;
    logic [3:0]            bank_onehot;
    logic                  csr_hit;
    logic                  last_beat;
    logic                  granted;

    assign bank_onehot = 4'b0001 << cur_addr[BANK_LSB+1:BANK_LSB];
    assign csr_hit     = (cur_addr >= CSR_BASE);
    assign last_beat   = (count == len_q - LEN_WIDTH'(1));
    assign granted     = (mem_bank_grant == bank_onehot);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (cmd_valid) state_nx = (cmd_len == '0) ? DONE : FETCH;
            FETCH: if (s_valid)   state_nx = csr_hit ? DONE : ARB;
            ARB:   if (granted)   state_nx = WRITE;
            WRITE: state_nx = last_beat ? DONE : FETCH;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // done/error are registered off the DONE state, so they land one cycle after it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cur_addr <= '0;
            len_q    <= '0;
            count    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            done_q  <= (state == DONE);
            error_q <= (state == DONE) && err_q;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr <= cmd_addr;
                        len_q    <= cmd_len;
                        count    <= '0;
                        err_q    <= 1'b0;
                    end
                end
                FETCH: begin
                    if (s_valid) begin
                        data_q <= s_data;
                        if (csr_hit) err_q <= 1'b1;
                    end
                end
                WRITE: begin
                    cur_addr <= cur_addr + ADDR_WIDTH'(1);
                    count    <= count + LEN_WIDTH'(1);
                end
                DONE: err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign cmd_ready    = (state == IDLE);
    assign s_ready      = (state == FETCH);
    assign mem_we       = (state == WRITE);
    assign mem_bank_req = ((state == ARB) || (state == WRITE)) ? bank_onehot : '0;
    assign mem_addr     = cur_addr;
    assign mem_wdata    = data_q;
    assign busy         = (state != IDLE);
    assign done         = done_q;
    assign error        = error_q;

`ifdef DMA_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if ((state == IDLE) && cmd_valid) begin
            stall_cycles <= '0;
        end else if ((((state == ARB) && !granted) || ((state == FETCH) && !s_valid))
                     && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_write_engine.sv
// Self-checking bench for dma_write_engine: command vector table, write scoreboard, reset-mid-ARB sequence.
module tb_dma_write_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_bank_req;
    logic [3:0]  mem_bank_grant;
    logic        done;
    logic        error;
    logic        busy;
`ifdef DMA_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    dma_write_engine #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .LEN_WIDTH (16),
        .BANK_LSB  (12),
        .CSR_BASE  (16'hFF00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_bank_req  (mem_bank_req),
        .mem_bank_grant(mem_bank_grant),
        .done          (done),
        .error         (error),
`ifdef DMA_STALL_CNT_EN
        .stall_cycles  (stall_cycles),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] len;
        logic [31:0] data0;
        int          arb_wait;
        int          exp_writes;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  bank;
    } wr_t;

    vec_t vecs[8];
    wr_t  sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [15:0] a;
        int          consumed_exp;
        int          consumed;
        int          idx;
        int          writes;
        int          cyc;
        int          wait_ctr;
        int          lat;
        int          nw_exp;
        int          spurious;
        bit          flag;
        logic        err_seen;
        wr_t         w;
        wr_t         got;

        a = v.addr;
        consumed_exp = 0;
        for (int i = 0; i < int'(v.len); i++) begin
            consumed_exp++;
            if (a >= 16'hFF00) break;
            w.addr = a;
            w.data = v.data0 + 32'(i);
            w.bank = 4'b0001 << a[13:12];
            sbq.push_back(w);
            a = a + 16'd1;
        end
        nw_exp = sbq.size();

        @(negedge clk);
        chk($sformatf("v%0d_cmd_ready", id), cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        idx       = 0;
        s_valid   = (v.len != 0);
        s_data    = v.data0;
        flag      = 0;
        consumed  = 0;
        writes    = 0;
        wait_ctr  = 0;
        lat       = -1;
        spurious  = 0;
        err_seen  = 1'b0;
        mem_bank_grant = '0;
        @(posedge clk);
        cyc = 0;
        while (cyc < 400 && lat < 0) begin
            @(negedge clk);
            cyc++;
            // junk commands while busy must be ignored
            if (busy) begin
                cmd_valid = 1'b1;
                cmd_addr  = ~v.addr;
                cmd_len   = 16'd7;
            end else begin
                cmd_valid = 1'b0;
            end
            if (mem_we) begin
                writes++;
                if (sbq.size() == 0) begin
                    chk($sformatf("v%0d_unexpected_write_addr", id), mem_addr, 16'hXXXX);
                end else begin
                    got = sbq.pop_front();
                    chk($sformatf("v%0d_wr_addr", id), mem_addr, got.addr);
                    chk($sformatf("v%0d_wr_data", id), mem_wdata, got.data);
                    chk($sformatf("v%0d_wr_bank", id), mem_bank_req, got.bank);
                end
            end
            if (flag) idx++;
            s_valid = (idx < int'(v.len));
            s_data  = v.data0 + 32'(idx);
            flag    = s_ready && s_valid;
            if (flag) consumed++;
            if (mem_bank_req != 4'b0000 && !mem_we) begin
                if (wait_ctr < v.arb_wait) begin
                    mem_bank_grant = {mem_bank_req[2:0], mem_bank_req[3]};
                    wait_ctr++;
                end else begin
                    mem_bank_grant = mem_bank_req;
                end
            end else begin
                mem_bank_grant = '0;
                wait_ctr = 0;
            end
            if (error && !done) spurious++;
            if (done) begin
                lat      = cyc;
                err_seen = error;
            end
        end
        s_valid   = 1'b0;
        cmd_valid = 1'b0;
        chk($sformatf("v%0d_latency", id), lat, v.exp_lat);
        chk($sformatf("v%0d_error", id), err_seen, v.exp_err);
        chk($sformatf("v%0d_writes", id), writes, v.exp_writes);
        chk($sformatf("v%0d_consumed", id), consumed, consumed_exp);
        chk($sformatf("v%0d_sb_left", id), sbq.size(), 0);
        chk($sformatf("v%0d_stray_error", id), spurious, 0);
`ifdef DMA_STALL_CNT_EN
        chk($sformatf("v%0d_stall_cycles", id), stall_cycles, nw_exp * v.arb_wait);
`endif
        @(negedge clk);
        chk($sformatf("v%0d_done_one_cycle", id), done, 0);
        sbq.delete();
    endtask

    initial begin
        int arb_seen;
        int done_cnt;

        vecs[0] = '{16'h0010, 16'd1, 32'hDEADBEEF, 0, 1, 1'b0, 5};
        vecs[1] = '{16'h0FFE, 16'd4, 32'h00000001, 0, 4, 1'b0, 14};
        vecs[2] = '{16'h2000, 16'd1, 32'hA5A50000, 6, 1, 1'b0, 11};
        vecs[3] = '{16'hFEFF, 16'd3, 32'h00000100, 0, 1, 1'b1, 6};
        vecs[4] = '{16'h0000, 16'd0, 32'h12345678, 0, 0, 1'b0, 2};
        vecs[5] = '{16'hFF00, 16'd2, 32'h0BADF00D, 0, 0, 1'b1, 3};
        vecs[6] = '{16'h3FFF, 16'd2, 32'h00000077, 2, 2, 1'b0, 12};
        vecs[7] = '{16'hFFFF, 16'd1, 32'hCAFEF00D, 0, 0, 1'b1, 3};

        reset          = 1'b1;
        cmd_valid      = 1'b0;
        cmd_addr       = '0;
        cmd_len        = '0;
        s_valid        = 1'b0;
        s_data         = '0;
        mem_bank_grant = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_bank_req", mem_bank_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // reset while waiting in ARB with grant withheld
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 16'h2000;
        cmd_len   = 16'd1;
        s_valid   = 1'b1;
        s_data    = 32'h55AA55AA;
        mem_bank_grant = '0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        arb_seen  = 0;
        for (int k = 0; k < 20 && arb_seen == 0; k++) begin
            if (mem_bank_req != 4'b0000) arb_seen = 1;
            else @(negedge clk);
        end
        chk("midarb_req", mem_bank_req, 4'b0100);
        #2 reset = 1'b1;
        #1;
        chk("midarb_rst_req", mem_bank_req, 0);
        chk("midarb_rst_we", mem_we, 0);
        chk("midarb_rst_cmd_ready", cmd_ready, 1);
        chk("midarb_rst_busy", busy, 0);
        @(negedge clk);
        reset   = 1'b0;
        s_valid = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || mem_we || busy) done_cnt++;
        end
        chk("midarb_no_activity", done_cnt, 0);

        run_vec(vecs[0], 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
